// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue in a FIFO.
// Registered outputs give one cycle of latency; ll_ready drops only while the FIFO is full.

// Circular-buffer FIFO; the caller never pushes when full and never pops when empty.
module syncFifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushDat,
  input  logic             pop,
  output logic [WIDTH-1:0] popDat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  assign popDat = mem[rdPtr];
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);

  // Storage carries no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushDat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module regfile_write_arbiter #(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_valid,
  input  logic                    wb_wen,
  input  logic [ADDRESS_SIZE-1:0] wb_rd,
  input  logic [DATA_SIZE-1:0]    wb_data,
  input  logic                    ll_valid,
  input  logic [ADDRESS_SIZE-1:0] ll_rd,
  input  logic [DATA_SIZE-1:0]    ll_data,
  output logic                    ll_ready,
  output logic                    RegWEn,
  output logic [ADDRESS_SIZE-1:0] AddrD,
  output logic [DATA_SIZE-1:0]    DataD,
  output logic [CNT_W-1:0]        fifo_count
);

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] rd;
    logic [DATA_SIZE-1:0]    data;
  } llEntry_t;

  localparam int unsigned ENTRY_W = $bits(llEntry_t);

  logic     pipeReq;
  logic     llFire;
  logic     llKeep;
  logic     fifoPush;
  logic     fifoPop;
  logic     fifoFull;
  logic     fifoEmpty;
  llEntry_t fifoIn;
  llEntry_t fifoHead;

  logic                    selWen;
  logic [ADDRESS_SIZE-1:0] selRd;
  logic [DATA_SIZE-1:0]    selData;

  assign pipeReq  = wb_valid && wb_wen && (wb_rd != '0);
  // ll_ready comes from the registered count alone, keeping it free of input-to-output paths.
  assign ll_ready = !fifoFull;
  assign llFire   = ll_valid && ll_ready;
  assign llKeep   = llFire && (ll_rd != '0);

  assign fifoIn.rd   = ll_rd;
  assign fifoIn.data = ll_data;

  syncFifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_llFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifoPush),
    .pushDat(fifoIn),
    .pop    (fifoPop),
    .popDat (fifoHead),
    .count  (fifo_count),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Pipeline first, then buffered results in order, then a same-cycle bypass when idle.
  always_comb begin
    fifoPush = 1'b0;
    fifoPop  = 1'b0;
    selWen   = 1'b0;
    selRd    = wb_rd;
    selData  = wb_data;
    if (pipeReq) begin
      selWen   = 1'b1;
      fifoPush = llKeep;
    end else if (!fifoEmpty) begin
      selWen   = 1'b1;
      fifoPop  = 1'b1;
      selRd    = fifoHead.rd;
      selData  = fifoHead.data;
      fifoPush = llKeep;
    end else if (llKeep) begin
      selWen   = 1'b1;
      selRd    = ll_rd;
      selData  = ll_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWEn <= 1'b0;
      AddrD  <= '0;
      DataD  <= '0;
    end else begin
      RegWEn <= selWen;
      if (selWen) begin
        AddrD <= selRd;
        DataD <= selData;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: each driven cycle queues its expected write,
// which is popped and compared against the port one clock later.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } wrItem_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        ll_ready;
  logic        RegWEn;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic [1:0]  fifo_count;

  int total = 0;
  int bad = 0;

  wrItem_t     expQ[$];
  wrItem_t     llModel[$];
  logic [4:0]  lastRd = '0;
  logic [31:0] lastData = '0;

  regfile_write_arbiter #(
    .DATA_SIZE(32), .ADDRESS_SIZE(5), .DEPTH(DEPTH), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle, predicts its write into expQ, then checks the port after the edge.
  task automatic cycle(input logic wbV, input logic wbW, input logic [4:0] wbRd,
                       input logic [31:0] wbD, input logic llV, input logic [4:0] llRd,
                       input logic [31:0] llD, output logic accepted);
    logic    expReady, fire, keep, pipe;
    wrItem_t llItem, e;
    wb_valid = wbV; wb_wen = wbW; wb_rd = wbRd; wb_data = wbD;
    ll_valid = llV; ll_rd = llRd; ll_data = llD;
    expReady = (llModel.size() < DEPTH);
    checkEq("ll_ready", ll_ready, expReady);
    fire   = llV && expReady;
    keep   = fire && (llRd != 5'd0);
    pipe   = wbV && wbW && (wbRd != 5'd0);
    llItem = '{1'b1, llRd, llD};
    if (pipe) begin
      expQ.push_back('{1'b1, wbRd, wbD});
      if (keep) llModel.push_back(llItem);
    end else if (llModel.size() > 0) begin
      expQ.push_back(llModel.pop_front());
      if (keep) llModel.push_back(llItem);
    end else if (keep) begin
      expQ.push_back(llItem);
    end else begin
      expQ.push_back('{1'b0, 5'd0, 32'd0});
    end
    accepted = fire;
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    if (e.wen) begin
      checkEq("wen", RegWEn, 1'b1);
      checkEq("addr", AddrD, e.rd);
      checkEq("data", DataD, e.data);
      lastRd = e.rd;
      lastData = e.data;
    end else begin
      checkEq("idle_wen", RegWEn, 1'b0);
      checkEq("hold_addr", AddrD, lastRd);
      checkEq("hold_data", DataD, lastData);
    end
    checkEq("fifo_count", fifo_count, llModel.size());
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
  endtask

  initial begin
    logic        acc;
    logic        pend;
    logic [4:0]  pRd;
    logic [31:0] pD;

    #1 rst_n = 1'b0;
    #10;
    checkEq("rst_wen", RegWEn, 1'b0);
    checkEq("rst_addr", AddrD, 5'd0);
    checkEq("rst_data", DataD, 32'd0);
    checkEq("rst_count", fifo_count, 2'd0);
    checkEq("rst_ready", ll_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Pipeline write, then hold
    cycle(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, acc);
    idle(1);

    // Bypass with empty FIFO
    cycle(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234, acc);
    checkEq("bypass_acc", acc, 1'b1);
    idle(1);

    // Collision: two buffered, third refused until the FIFO drains
    cycle(1, 1, 5'd3, 32'hA, 1, 5'd8, 32'h11, acc);
    cycle(1, 1, 5'd3, 32'hA, 1, 5'd9, 32'h22, acc);
    checkEq("coll_count2", fifo_count, 2'd2);
    cycle(1, 1, 5'd3, 32'hA, 1, 5'd10, 32'h33, acc);
    checkEq("coll_refused", acc, 1'b0);
    cycle(0, 0, 5'd0, 32'd0, 1, 5'd10, 32'h33, acc);
    checkEq("coll_still_refused", acc, 1'b0);
    cycle(0, 0, 5'd0, 32'd0, 1, 5'd10, 32'h33, acc);
    checkEq("coll_third_acc", acc, 1'b1);
    idle(3);

    // Simultaneous push/pop across pointer wrap
    cycle(1, 1, 5'd1, 32'hF0, 1, 5'd20, 32'h100, acc);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 5'd0, 32'd0, 1, 5'(21 + i), 32'h101 + i, acc);
      checkEq("pp_count1", fifo_count, 2'd1);
    end
    idle(2);

    // x0 suppression on both sources
    cycle(1, 1, 5'd0, 32'hBAD, 1, 5'd0, 32'hBAD0, acc);
    checkEq("x0_acc", acc, 1'b1);
    checkEq("x0_wen", RegWEn, 1'b0);
    checkEq("x0_count", fifo_count, 2'd0);
    idle(1);

    // Mid-stream async reset with two entries buffered
    cycle(1, 1, 5'd4, 32'h44, 1, 5'd12, 32'hC0, acc);
    cycle(1, 1, 5'd4, 32'h45, 1, 5'd13, 32'hC1, acc);
    checkEq("pre_rst_count", fifo_count, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    checkEq("mid_rst_wen", RegWEn, 1'b0);
    checkEq("mid_rst_addr", AddrD, 5'd0);
    checkEq("mid_rst_data", DataD, 32'd0);
    checkEq("mid_rst_count", fifo_count, 2'd0);
    checkEq("mid_rst_ready", ll_ready, 1'b1);
    wb_valid = 0; ll_valid = 0;
    llModel.delete();
    expQ.delete();
    lastRd = '0;
    lastData = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Random traffic obeying the hold-while-stalled rule
    pend = 0; pRd = '0; pD = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1;
        pRd  = 5'($urandom_range(0, 31));
        pD   = $urandom;
      end
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
            5'($urandom_range(0, 31)), $urandom, pend, pRd, pD, acc);
      if (acc) pend = 0;
    end
    ll_valid = 0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Initiator side of the register-file write port (RegWEn/AddrD/DataD).
- Merges two result sources into the single write port:
  - the in-order pipeline writeback stream, which has fixed priority;
  - a long-latency unit (divider / load-miss return) using a valid/ready handshake, buffered in a small FIFO.
- Outputs are registered on posedge, so the register file's negedge write lands mid-cycle with stable address and data.

Parameters:
- DATA_SIZE, 32, width of write data
- ADDRESS_SIZE, 5, width of register address
- DEPTH, 2, long-latency FIFO entries (power of 2, >=2)
- CNT_W, 2, width of fifo_count, equal to log2(DEPTH)+1

Ports:
- clk  in  1  clock, posedge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline writeback slot valid this cycle
- wb_wen  in  1  pipeline instruction writes rd
- wb_rd  in  ADDRESS_SIZE  pipeline destination register
- wb_data  in  DATA_SIZE  pipeline result
- ll_valid  in  1  long-latency result offered
- ll_rd  in  ADDRESS_SIZE  long-latency destination register
- ll_data  in  DATA_SIZE  long-latency result
- ll_ready  out  1  arbiter accepts long-latency result this cycle
- RegWEn  out  1  register-file write enable (1 = READ_WRITE)
- AddrD  out  ADDRESS_SIZE  register-file write address
- DataD  out  DATA_SIZE  register-file write data
- fifo_count  out  CNT_W  occupied FIFO entries

Behaviour:
- Reset (rst_n=0, async): RegWEn=0, AddrD=0, DataD=0, FIFO emptied (pointers and count 0), fifo_count=0.
- Reset mid-operation discards all buffered entries; entries are not replayed after reset.
- ll_ready = (count < DEPTH). It depends on registered count only, with no combinational path from wb_* or ll_valid.
- Handshake:
  - ll transfer occurs when ll_valid && ll_ready.
  - The source holds ll_rd/ll_data stable while ll_valid=1 and ll_ready=0.
- pipe_req = wb_valid && wb_wen && (wb_rd != 0).
- Per-cycle selection, evaluated on each posedge, in priority order:
  1. pipe_req: write the pipeline result next cycle. An accepted ll transfer is pushed into the FIFO if its rd != 0.
  2. else if count > 0: pop the FIFO head and write it. An accepted ll transfer is pushed in the same cycle (simultaneous push/pop; count unchanged).
  3. else if the ll transfer is accepted and ll_rd != 0: bypass it straight to the write port without touching the FIFO.
  4. else: no write.
- Write to x0:
  - An accepted ll transfer with ll_rd=0 is consumed and discarded; it is never pushed.
  - A pipeline write with wb_rd=0 produces no write.
- Output timing:
  - When a write is selected, RegWEn=1 and AddrD/DataD are loaded at that posedge, giving a latency of 1 cycle from input to port.
  - When no write is selected, RegWEn=0 and AddrD/DataD hold their previous values.
- FIFO is a circular buffer. Pointers wrap modulo DEPTH. count range is 0..DEPTH.
- Ordering and hazards: RAW/WAW hazards between pipeline and long-latency destinations are prevented upstream by the scoreboard. The arbiter performs no rd-match cancellation. FIFO entries drain strictly in acceptance order.
- Starvation: the FIFO drains only in cycles without pipe_req. With a full FIFO and continuous pipe_req, ll_ready stays 0, which is legal backpressure.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 entries buffered -> RegWEn=0, AddrD=0, DataD=0, fifo_count=0, ll_ready=1 immediately, without waiting for a clock edge.
- Pipeline only: wb_valid=1, wb_wen=1, wb_rd=5, wb_data=32'hDEADBEEF -> next cycle RegWEn=1, AddrD=5, DataD=32'hDEADBEEF. Next cycle wb_valid=0 -> RegWEn=0, AddrD/DataD unchanged.
- Bypass: FIFO empty, no pipe_req, ll_valid=1, ll_rd=7, ll_data=32'h1234 -> ll_ready=1. Next cycle AddrD=7, DataD=32'h1234, and fifo_count stays 0.
- Collision and buffering:
  - Stimulus: pipe_req (rd=3, data 0xA) for 3 cycles while ll offers rd=8/0x11, rd=9/0x22, rd=10/0x33 back-to-back.
  - Required: the first two are accepted and fifo_count reaches 2, then ll_ready=0 on the third.
  - Once pipe_req is dropped, writes appear in order x8=0x11, x9=0x22, then x10=0x33.
- Simultaneous push/pop: count=1, no pipe_req, new ll accepted -> head written, new entry pushed, fifo_count stays 1, and order is preserved across pointer wrap (run 6 entries).
- x0 suppression: ll_rd=0 with ll_valid=1, and wb_rd=0 with wb_wen=1 -> both handshakes complete, RegWEn remains 0, and fifo_count remains 0.
